mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/sisc_pkg.sv | 28 ++
 rtl/lat_cnt.sv | 38 +++
 rtl/mem_arb.sv | 176 +++++++++++++++++
 tb/tb_mem_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester
// IDs, starvation-guard limit and the arbitration helper.
package sisc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Number of back-to-back data grants tolerated while a fetch is waiting.
  localparam logic [1:0] GUARD_LIMIT = 2'd2;

  localparam int STALL_W = 16;

  // Data wins unless a fetch is pending and has already been passed over
  // GUARD_LIMIT times in a row.
  function automatic logic pick_data(input logic       i_req,
                                     input logic       d_req,
                                     input logic [1:0] guard);
    return d_req && (!i_req || (guard < GUARD_LIMIT));
  endfunction

endpackage

// File: rtl/lat_cnt.sv
// Memory latency counter: cleared by load_i, advances while count_i is high,
// tc_o flags that MEM_LAT-1 counts have elapsed since the last load.
module lat_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic tc_o
);

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  logic [2:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise advance and saturate at the top value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 3'd0;
    end else if (count_i && (cnt_q != 3'd7)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q >= LAST);

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter (fetch, data) for a single fixed-latency memory port.
// Optional build macro MEM_ARB_STATS_EN adds the 16-bit stall_cnt output.
//
// Requester protocol: a requester raises req with its address/data and holds
// them level until its done pulse. The arbiter samples requests only in IDLE;
// the winner sees gnt for one cycle (GRANT) and done for one cycle (DONE), and
// read data on rdata is valid only in that done cycle. A req dropped before gnt
// is forgotten; once granted, the access completes regardless of req.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        dbg_state,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  , output logic [STALL_W-1:0] stall_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        guard_q, guard_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win_data;
  logic              lat_tc;

  assign win_data = pick_data(i_req, d_req, guard_q);

  lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == ST_IDLE),
    .count_i ((state_q == ST_GRANT) || (state_q == ST_WAIT)),
    .tc_o    (lat_tc)
  );

  // Next-state, access capture and output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    guard_d = guard_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    mem_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_GRANT;
          owner_d = win_data ? REQ_DATA : REQ_FETCH;
          addr_d  = win_data ? d_addr : i_addr;
          we_d    = win_data && d_we;
          wdata_d = win_data ? d_wdata : '0;
          // A data win can only happen below the limit, so this never wraps.
          guard_d = (win_data && i_req) ? (guard_q + 2'd1) : 2'd0;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT;
        mem_en  = 1'b1;
        i_gnt   = (owner_q == REQ_FETCH);
        d_gnt   = (owner_q == REQ_DATA);
      end
      ST_WAIT: begin
        if (lat_tc) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        i_done  = (owner_q == REQ_FETCH);
        d_done  = (owner_q == REQ_DATA);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and access registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_FETCH;
      guard_q <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      guard_q <= guard_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               i_served, d_served, stall_now;

  // A requester is served when it is being picked in IDLE or owns the access.
  always_comb begin
    i_served  = 1'b0;
    d_served  = 1'b0;
    stall_d   = stall_q;
    if (state_q == ST_IDLE) begin
      i_served = (i_req || d_req) && !win_data;
      d_served = win_data;
    end else begin
      i_served = (owner_q == REQ_FETCH);
      d_served = (owner_q == REQ_DATA);
    end
    stall_now = (i_req && !i_served) || (d_req && !d_served);
    if (stall_now && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of single transactions plus hand-written
// sequences for contention, starvation guard and reset in flight.
module tb_mem_arb;
  import sisc_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_gnt, d_gnt, i_done, d_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  arb_state_e        dbg_state;
  logic              busy;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_arb #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .i_gnt     (i_gnt),
    .d_gnt     (d_gnt),
    .i_done    (i_done),
    .d_done    (d_done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state),
    .busy      (busy)
`ifdef MEM_ARB_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset-free infrastructure ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  // Unwritten words read back as C0DE00xx so every address has a known value.
  logic [DATA_W-1:0] mem_q [0:255];
  logic [255:0]      written_q;
  logic [7:0]        rd_idx_q = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
    end else if (mem_en) begin
      rd_idx_q <= mem_addr[7:0];
      if (mem_we) begin
        mem_q[mem_addr[7:0]]     <= mem_wdata;
        written_q[mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  assign mem_rdata = written_q[rd_idx_q] ? mem_q[rd_idx_q] : {16'hC0DE, 8'h00, rd_idx_q};

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rdata(input string name);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk(name, rdata, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drop_all();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  typedef struct {
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              exp_data;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_we;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // One transaction from IDLE; both requests dropped in the DONE cycle.
  task automatic run_vec(input vec_t v, input int n);
    i_req   = v.i_req;
    i_addr  = v.i_addr;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    if (!v.exp_we) exp_q.push_back(v.exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d_i_gnt", n), i_gnt, !v.exp_data);
    chk($sformatf("v%0d_d_gnt", n), d_gnt, v.exp_data);
    chk($sformatf("v%0d_mem_en", n), mem_en, 1);
    chk($sformatf("v%0d_mem_addr", n), mem_addr, v.exp_addr);
    chk($sformatf("v%0d_mem_we", n), mem_we, v.exp_we);
    if (v.exp_we) chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.d_wdata);
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_wait_en", n), {mem_en, i_gnt, d_gnt, busy}, 4'b0001);
      chk($sformatf("v%0d_wait_addr", n), mem_addr, v.exp_addr);
    end
    @(negedge clk);
    chk($sformatf("v%0d_i_done", n), i_done, !v.exp_data);
    chk($sformatf("v%0d_d_done", n), d_done, v.exp_data);
    chk($sformatf("v%0d_done_we", n), mem_we, v.exp_we);
    if (!v.exp_we) chk_rdata($sformatf("v%0d_rdata", n));
    drop_all();
    @(negedge clk);
    chk($sformatf("v%0d_idle", n), {busy, i_gnt, d_gnt}, 3'b000);
  endtask

  // ---------------- test ----------------
  logic        order_q[$];
  int          times_q[$];
  logic        exp_order[4];
  int          dcount;
  bit          timed_out;

  initial begin
    rst = 1'b1;
    drop_all();
    i_addr = '0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 16'h0010, 1'b0, 32'hC0DE0010};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 32'h0,        1'b1, 16'h0030, 1'b0, 32'hC0DE0030};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 32'hDEADBEEF, 1'b1, 16'h0020, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 32'h0,        1'b1, 16'h0020, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 16'h0011, 1'b1, 1'b0, 16'h0031, 32'h0,        1'b1, 16'h0031, 1'b0, 32'hC0DE0031};
    vecs[5] = '{1'b1, 16'h0012, 1'b1, 1'b1, 16'h0040, 32'h12345678, 1'b1, 16'h0040, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 16'h0013, 1'b1, 1'b1, 16'h0040, 32'hFFFFFFFF, 1'b0, 16'h0013, 1'b0, 32'hC0DE0013};
    vecs[7] = '{1'b1, 16'h0014, 1'b1, 1'b0, 16'h0040, 32'h0,        1'b1, 16'h0040, 1'b0, 32'h12345678};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, mem_en, mem_we, i_gnt, d_gnt, i_done, d_done}, 7'd0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", dbg_state, ST_IDLE);
`ifdef MEM_ARB_STATS_EN
    chk("rst_stall", stall_cnt, 0);
`endif

    // Simultaneous requests on the first edge after reset: data first.
    rst = 1'b0;
    i_req = 1'b1; i_addr = 16'h0070;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0071;
    exp_q.push_back(32'hC0DE0071);
    @(negedge clk);
    chk("sim_d_gnt", {d_gnt, i_gnt}, 2'b10);
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    chk("sim_d_done", {d_done, i_done}, 2'b10);
    chk_rdata("sim_d_rdata");
    d_req = 1'b0;
    @(negedge clk);
    chk("sim_idle_no_gnt", {busy, i_gnt, d_gnt}, 3'b000);
    exp_q.push_back(32'hC0DE0070);
    @(negedge clk);
    chk("sim_i_gnt", {i_gnt, d_gnt, mem_we}, 3'b100);
    chk("sim_i_addr", mem_addr, 16'h0070);
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    chk("sim_i_done", i_done, 1);
    chk_rdata("sim_i_rdata");
    i_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    chk("sim_stall_cnt", stall_cnt, 4);
`endif

    // Table of single transactions.
    for (int n = 0; n < 8; n++) begin
      run_vec(vecs[n], n);
      if (n == 2) chk("store_in_mem", mem_q[8'h20], 32'hDEADBEEF);
    end

    // Reset while waiting on memory, then a fresh grant.
    i_req = 1'b1; i_addr = 16'h0080;
    @(negedge clk);
    chk("rw_gnt", i_gnt, 1);
    @(negedge clk);
    chk("rw_in_wait", dbg_state, ST_WAIT);
    #1 rst = 1'b1;
    #1;
    chk("rw_ctrl_zero", {busy, mem_en, mem_we, i_gnt, d_gnt, i_done, d_done}, 7'd0);
    chk("rw_addr_zero", mem_addr, 0);
    chk("rw_rdata_zero", rdata, 0);
    @(negedge clk);
    chk("rw_no_done", {i_done, d_done, busy}, 3'b000);
    rst = 1'b0;
    exp_q.push_back(32'hC0DE0080);
    @(negedge clk);
    chk("rw_fresh_gnt", {i_gnt, mem_en}, 2'b11);
    chk("rw_fresh_addr", mem_addr, 16'h0080);
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    chk("rw_fresh_done", i_done, 1);
    chk_rdata("rw_fresh_rdata");
    i_req = 1'b0;
    @(negedge clk);

    // Starvation guard: fetch held while data runs three accesses.
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1};
    i_req = 1'b1; i_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    dcount = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        order_q.push_back(d_gnt);
        times_q.push_back(c);
      end
      if (d_done) begin
        dcount++;
        if (dcount == 3) d_req = 1'b0;
      end
      if (i_done) i_req = 1'b0;
      if (!i_req && !d_req) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("starve_timeout", timed_out, 0);
    drop_all();
    chk("starve_count", order_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < order_q.size()) chk($sformatf("starve_order%0d", k), order_q[k], exp_order[k]);
      if (k + 1 < times_q.size())
        chk($sformatf("starve_gap%0d", k), times_q[k+1] - times_q[k], LAT + 2);
    end
    @(negedge clk);
    chk("end_idle", busy, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
